// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, syncs, visible flag, coordinates and line/frame strobes.
// Latency: all outputs registered together with the counters; no backpressure (free-running raster).
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pce_q, pce_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic             ls_q, ls_d, fs_q, fs_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pce_d = (div_d == DIV_LAST);
        x_d   = x_q;
        y_d   = y_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (pce_q) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Flags decode the next coordinates so they land in the same cycle as DrawX/DrawY.
        hs_d    = !((x_d >= HS_BEG) && (x_d < HS_END));
        vs_d    = !((y_d >= VS_BEG) && (y_d < VS_END));
        blank_d = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div_q   <= '0;
            pce_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            pce_q   <= pce_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign pixel_ce    = pce_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shrunken raster, CLK_DIV=2 and CLK_DIV=1 instances side by side.
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NPIX = HT * VT;

    typedef struct packed {
        logic       pce, hs, vs, blank, sync, ls, fs;
        logic [9:0] x, y;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic pce0, hs0, vs0, bl0, sy0, ls0, fs0;
    logic pce1, hs1, vs1, bl1, sy1, ls1, fs1;
    logic [9:0] x0, y0, x1, y1;

    vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u0 (
        .Clk(clk), .Reset(rst_n), .pixel_ce(pce0), .hs(hs0), .vs(vs0), .blank(bl0),
        .sync(sy0), .DrawX(x0), .DrawY(y0), .line_start(ls0), .frame_start(fs0));

    vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u1 (
        .Clk(clk), .Reset(rst_n), .pixel_ce(pce1), .hs(hs1), .vs(vs1), .blank(bl1),
        .sync(sy1), .DrawX(x1), .DrawY(y1), .line_start(ls1), .frame_start(fs1));

    out_t q0[$], q1[$];
    int checks = 0, errors = 0;
    int t = 0, cyc = 0;
    bit in_rst = 1'b1;
    int last_fs0 = -1, last_fs1 = -1, last_ls0 = -1, last_ls1 = -1;
    int vis0 = 0, vis1 = 0, maxx = 0, maxy = 0, hs_run1 = 0, nfs0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Closed-form raster position from cycles since reset release.
    function automatic out_t model(input int d, input int tt, input bit r);
        out_t o;
        int n, xi, yi;
        bit adv;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (!r) begin
            if (d == 1) begin
                n = (tt >= 2) ? tt - 1 : 0;
                adv = (tt >= 2);
                o.pce = (tt >= 1);
            end else begin
                n = tt / d;
                adv = (tt % d == 0) && (tt > 0);
                o.pce = (tt % d == d - 1);
            end
            xi = n % HT;
            yi = (n / HT) % VT;
            o.x = 10'(xi);
            o.y = 10'(yi);
            o.hs = !(xi >= HV + HF && xi < HV + HF + HS);
            o.vs = !(yi >= VV + VF && yi < VV + VF + VS);
            o.blank = (xi < HV) && (yi < VV);
            o.ls = adv && (xi == 0);
            o.fs = adv && (n % NPIX == 0);
        end
        return o;
    endfunction

    task automatic tick();
        out_t e0, e1, o0, o1;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            in_rst = 1'b1;
            t = 0;
        end else begin
            in_rst = 1'b0;
            t++;
        end
        q0.push_back(model(2, t, in_rst));
        q1.push_back(model(1, t, in_rst));
        @(negedge clk);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        o0 = out_t'({pce0, hs0, vs0, bl0, sy0, ls0, fs0, x0, y0});
        o1 = out_t'({pce1, hs1, vs1, bl1, sy1, ls1, fs1, x1, y1});
        check("outputs_div2", 32'(o0), 32'(e0));
        check("outputs_div1", 32'(o1), 32'(e1));
        if (in_rst) begin
            last_fs0 = -1; last_fs1 = -1; last_ls0 = -1; last_ls1 = -1;
            hs_run1 = 0;
        end else begin
            if (int'(x0) > maxx) maxx = int'(x0);
            if (int'(y0) > maxy) maxy = int'(y0);
            if (pce0 && bl0 && t <= 2 * NPIX) vis0++;
            if (pce1 && bl1 && t <= NPIX) vis1++;
            if (fs0) begin
                nfs0++;
                if (last_fs0 < 0) begin
                    check("first_frame_time_div2", 32'(t), 32'(2 * NPIX));
                    check("first_frame_pos", {ls0, 11'd0, x0, y0}, {1'b1, 31'd0});
                end else begin
                    check("frame_period_div2", 32'(cyc - last_fs0), 32'(2 * NPIX));
                end
                last_fs0 = cyc;
            end
            if (fs1) begin
                if (last_fs1 >= 0) check("frame_period_div1", 32'(cyc - last_fs1), 32'(NPIX));
                last_fs1 = cyc;
            end
            if (ls0) begin
                if (last_ls0 >= 0) check("line_period_div2", 32'(cyc - last_ls0), 32'(2 * HT));
                last_ls0 = cyc;
            end
            if (ls1) begin
                if (last_ls1 >= 0) check("line_period_div1", 32'(cyc - last_ls1), 32'(HT));
                last_ls1 = cyc;
            end
            if (!hs1) hs_run1++;
            else if (hs_run1 > 0) begin
                check("hs_width_div1", 32'(hs_run1), 32'(HS));
                hs_run1 = 0;
            end
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        repeat (5) tick();
        check("reset_state", {pce0, hs0, vs0, bl0, sy0, ls0, fs0, x0, y0},
              {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0});
        rst_n = 1'b1;
        repeat (3 * 2 * NPIX + 10) tick();
        check("visible_count_div2", 32'(vis0), 32'(HV * VV));
        check("visible_count_div1", 32'(vis1), 32'(HV * VV));
        check("max_drawx", 32'(maxx), 32'(HT - 1));
        check("max_drawy", 32'(maxy), 32'(VT - 1));
        check("frames_seen", 32'(nfs0), 32'd3);

        found = 1'b0;
        for (int i = 0; i < 2 * NPIX + 4 && !found; i++) begin
            if (x0 == 10'(HV + HF + 2) && y0 == 10'(VV + VF + 1)) found = 1'b1;
            else tick();
        end
        check("reached_reset_point", 32'(found), 32'd1);
        check("in_both_syncs", {hs0, vs0}, 2'b00);
        rst_n = 1'b0;
        tick();
        check("midframe_reset", {hs0, vs0, bl0, fs0, ls0, pce0, x0, y0},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0});
        rst_n = 1'b1;
        repeat (2 * NPIX + 20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces VGA raster timing: hs/vs syncs, the visible-region flag `blank`, and the pixel coordinates DrawX/DrawY.
- It is the producer side of the pixel interface that the color mapper consumes.
- Runs on the 50 MHz system clock and advances one pixel per pixel-clock enable.
- Also emits line/frame strobes so game logic (tank/bullet position update) can step once per frame.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- pixel_ce  out  1  one-Clk-wide pixel enable, every CLK_DIV cycles
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible region (color mapper drives RGB), 0 = blanking
- sync  out  1  composite sync to DAC, tied 0
- DrawX  out  10  horizontal pixel counter, 0..H_TOTAL-1
- DrawY  out  10  vertical line counter, 0..V_TOTAL-1
- line_start  out  1  one-Clk pulse at start of each line
- frame_start  out  1  one-Clk pulse at start of each frame

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525). Both must be <=1024.
- Reset (Reset=0 at a Clk edge):
  - div=0, DrawX=0, DrawY=0, pixel_ce=0.
  - hs=1, vs=1, blank=0, line_start=0, frame_start=0.
  - Reset applies in any state mid-frame and takes priority over all counting.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_ce=1 exactly in Clk cycles where div==CLK_DIV-1.
  - With CLK_DIV=1, pixel_ce=1 every cycle after reset release.
- Counters update only on Clk edges where pixel_ce=1:
  - DrawX==H_TOTAL-1: DrawX<=0, and DrawY<=(DrawY==V_TOTAL-1)?0:DrawY+1.
  - Otherwise DrawX<=DrawX+1 and DrawY holds.
- hs, vs and blank are registered together with the counters, so in every cycle they describe the current (DrawX, DrawY). No skew is allowed between coordinates and flags.
  - hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE.
- Strobes:
  - line_start=1 for the single Clk cycle immediately after the counter edge that sets DrawX to 0.
  - frame_start=1 for the single Clk cycle immediately after the counter edge that sets (DrawX,DrawY) to (0,0).
  - Neither strobe fires on reset release. The first frame_start occurs after one complete frame.
  - On a frame wrap, line_start and frame_start assert in the same cycle.
- Timing totals:
  - Frame period is H_TOTAL*V_TOTAL*CLK_DIV Clk cycles (840000 default).
  - Line period is H_TOTAL*CLK_DIV Clk cycles (1600).
- sync is constant 0 in all states, including reset.
- No combinational path from any input to any output.

Test Plan:
- Reset held low 5 cycles, then released -> all outputs equal reset values. pixel_ce first high on Clk cycle 2 after release. DrawX=1 after that edge.
- Run one line from reset -> hs falls when DrawX becomes 656 (Clk 1312 after release), rises when DrawX becomes 752. blank falls when DrawX becomes 640. line_start pulses once when DrawX returns to 0, with DrawY=1.
- Run a full frame -> vs low only while DrawY is 490..491. blank=0 for all DrawY>=480.
  - Count exactly 307200 cycles with blank=1 && pixel_ce=1.
  - frame_start first pulses 840000 Clk after release, with (DrawX,DrawY)=(0,0) and line_start also high.
- Run multiple frames -> check periods:
  - Consecutive frame_start pulses are exactly 840000 Clk apart.
  - Consecutive line_start pulses are exactly 1600 Clk apart.
  - DrawX never exceeds 799 and DrawY never exceeds 524.
- Assert reset at (DrawX,DrawY)=(700,491), during both syncs -> next cycle: hs=1, vs=1, DrawX=0, DrawY=0, blank=0, no frame_start pulse.
- Re-instantiate with CLK_DIV=1 -> pixel_ce constantly 1 after reset, frame period 420000 Clk, hs low for 96 consecutive Clk cycles per line.
